// File: rtl/sm_io_pkg.sv
// Shared constants, repeat FSM encoding and counter sizing for the input-conditioning blocks.
package sm_io_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 1024;
    localparam int DEF_REPEAT_PERIOD   = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to hold 0..n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sm_debounce_ch.sv
// One input channel: 2-flop sync, polarity fix, debounce counter, registered edge pulses.
// Auto-repeat FSM is built only when SM_KEY_REPEAT_EN is defined.
module sm_debounce_ch
    import sm_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic key_state,
    output logic key_press,
    output logic key_release
);

    localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_LVL = (ACTIVE_LOW != 0);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          pressed;
    logic          accept;
    logic          press_d;
    logic          release_d;
    logic          key_fire;

    // Reset to the idle pin level so a held key never looks like an edge at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {2{IDLE_LVL}};
        else        sync_q <= {sync_q[0], raw};
    end

    assign pressed   = sync_q[1] ^ IDLE_LVL;
    assign accept    = (pressed != key_state) && (cnt_q == CNT_LAST);
    assign press_d   = accept & pressed;
    assign release_d = accept & ~pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= key_fire;
            key_release <= release_d;
            if (pressed == key_state) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                key_state <= pressed;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef SM_KEY_REPEAT_EN
    localparam int            RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW      = cnt_w(RMAX);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    rpt_state_e    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: begin
                if (press_d) begin
                    state_d = DELAY;
                    rcnt_d  = '0;
                end
            end
            DELAY: begin
                if (rcnt_q == RD_LAST) begin
                    state_d = REPEAT;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (rcnt_q == RP_LAST) rcnt_d = '0;
                else                   rcnt_d = rcnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                rcnt_d  = '0;
            end
        endcase
        // A debounced release always wins over any pending repeat.
        if (release_d) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end
    end

    always_comb begin
        rpt_fire = 1'b0;
        case (state_q)
            DELAY:   rpt_fire = (rcnt_q == RD_LAST);
            REPEAT:  rpt_fire = (rcnt_q == RP_LAST);
            default: rpt_fire = 1'b0;
        endcase
    end

    assign key_fire = press_d | (rpt_fire & ~release_d);
`else
    assign key_fire = press_d;
`endif

endmodule

// File: rtl/sm_key_debounce.sv
// Board input conditioning: WIDTH independent debounced channels plus sticky, clearable event flags.
// Optional auto-repeat: define SM_KEY_REPEAT_EN.
module sm_key_debounce
    import sm_io_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rawIn,
    output logic [WIDTH-1:0] keyState,
    output logic [WIDTH-1:0] keyPress,
    output logic [WIDTH-1:0] keyRelease,
    output logic [WIDTH-1:0] keyEvent,
    input  logic [WIDTH-1:0] eventClr
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sm_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (rawIn[i]),
            .key_state   (keyState[i]),
            .key_press   (keyPress[i]),
            .key_release (keyRelease[i])
        );
    end

    // Set beats clear so a press landing on a clear is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) keyEvent <= '0;
        else        keyEvent <= (keyEvent & ~eventClr) | keyPress;
    end

endmodule

// File: tb/tb_sm_key_debounce.sv
// Directed bench for sm_key_debounce (WIDTH=4, DEBOUNCE_CYCLES=4, active-low keys).
module tb_sm_key_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] rawIn;
    logic [3:0] keyState;
    logic [3:0] keyPress;
    logic [3:0] keyRelease;
    logic [3:0] keyEvent;
    logic [3:0] eventClr;

    int total = 0;
    int bad   = 0;

    sm_key_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rawIn      (rawIn),
        .keyState   (keyState),
        .keyPress   (keyPress),
        .keyRelease (keyRelease),
        .keyEvent   (keyEvent),
        .eventClr   (eventClr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] es, ep, ee, er;
        rst_n = 1'b0; rawIn = 4'b1110; eventClr = 4'b0;
        repeat (3) tick();
        total++; if (keyState !== 4'b0)   begin bad++; $display("FAIL rst_state got=%b exp=0000", keyState); end
        total++; if (keyPress !== 4'b0)   begin bad++; $display("FAIL rst_press got=%b exp=0000", keyPress); end
        total++; if (keyRelease !== 4'b0) begin bad++; $display("FAIL rst_release got=%b exp=0000", keyRelease); end
        total++; if (keyEvent !== 4'b0)   begin bad++; $display("FAIL rst_event got=%b exp=0000", keyEvent); end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            es = (k >= 6) ? 4'b0001 : 4'b0;
            ep = (k == 6) ? 4'b0001 : 4'b0;
            ee = (k >= 7) ? 4'b0001 : 4'b0;
            total++; if (keyState !== es) begin bad++; $display("FAIL held_state edge=%0d got=%b exp=%b", k, keyState, es); end
            total++; if (keyPress !== ep) begin bad++; $display("FAIL held_press edge=%0d got=%b exp=%b", k, keyPress, ep); end
            total++; if (keyEvent !== ee) begin bad++; $display("FAIL held_event edge=%0d got=%b exp=%b", k, keyEvent, ee); end
        end
        rawIn = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            tick();
            es = (k >= 6) ? 4'b0 : 4'b0001;
            er = (k == 6) ? 4'b0001 : 4'b0;
            total++; if (keyState !== es)   begin bad++; $display("FAIL rel_state edge=%0d got=%b exp=%b", k, keyState, es); end
            total++; if (keyRelease !== er) begin bad++; $display("FAIL rel_pulse edge=%0d got=%b exp=%b", k, keyRelease, er); end
        end
        eventClr = 4'b0001;
        tick();
        eventClr = 4'b0;
        total++; if (keyEvent !== 4'b0) begin bad++; $display("FAIL rel_evclr got=%b exp=0000", keyEvent); end
    endtask

    task automatic test_press();
        logic [3:0] es, ep;
        rawIn = 4'b1101;
        for (int k = 1; k <= 7; k++) begin
            tick();
            es = (k >= 6) ? 4'b0010 : 4'b0;
            ep = (k == 6) ? 4'b0010 : 4'b0;
            total++; if (keyState !== es) begin bad++; $display("FAIL press_state edge=%0d got=%b exp=%b", k, keyState, es); end
            total++; if (keyPress !== ep) begin bad++; $display("FAIL press_pulse edge=%0d got=%b exp=%b", k, keyPress, ep); end
        end
        repeat (3) begin
            tick();
            total++; if (keyEvent !== 4'b0010) begin bad++; $display("FAIL press_sticky got=%b exp=0010", keyEvent); end
        end
        eventClr = 4'b0010;
        tick();
        eventClr = 4'b0;
        total++; if (keyEvent !== 4'b0)    begin bad++; $display("FAIL press_clr got=%b exp=0000", keyEvent); end
        total++; if (keyState !== 4'b0010) begin bad++; $display("FAIL press_hold got=%b exp=0010", keyState); end
        rawIn = 4'b1111;
        repeat (8) tick();
        total++; if (keyState !== 4'b0) begin bad++; $display("FAIL press_relall got=%b exp=0000", keyState); end
        total++; if (keyEvent !== 4'b0) begin bad++; $display("FAIL press_noev got=%b exp=0000", keyEvent); end
    endtask

    task automatic test_bounce();
        logic [3:0] ep;
        for (int seg = 0; seg < 10; seg++) begin
            rawIn = (seg % 2 == 0) ? 4'b1011 : 4'b1111;
            repeat (2) begin
                tick();
                total++; if (keyState !== 4'b0) begin bad++; $display("FAIL bounce_state seg=%0d got=%b exp=0000", seg, keyState); end
                total++; if (keyPress !== 4'b0) begin bad++; $display("FAIL bounce_press seg=%0d got=%b exp=0000", seg, keyPress); end
            end
        end
        rawIn = 4'b1011;
        for (int k = 1; k <= 7; k++) begin
            tick();
            ep = (k == 6) ? 4'b0100 : 4'b0;
            total++; if (keyPress !== ep) begin bad++; $display("FAIL settle_press edge=%0d got=%b exp=%b", k, keyPress, ep); end
        end
        rawIn = 4'b1111;
        repeat (8) tick();
        eventClr = 4'b0100;
        tick();
        eventClr = 4'b0;
        total++; if (keyEvent !== 4'b0) begin bad++; $display("FAIL settle_clr got=%b exp=0000", keyEvent); end
    endtask

    task automatic test_set_wins();
        rawIn = 4'b0111;
        repeat (6) tick();
        total++; if (keyPress !== 4'b1000) begin bad++; $display("FAIL sw_press got=%b exp=1000", keyPress); end
        total++; if (keyEvent !== 4'b0)    begin bad++; $display("FAIL sw_pre_event got=%b exp=0000", keyEvent); end
        eventClr = 4'b1000;
        tick();
        eventClr = 4'b0;
        total++; if (keyEvent !== 4'b1000) begin bad++; $display("FAIL sw_event got=%b exp=1000", keyEvent); end
        total++; if (keyPress !== 4'b0)    begin bad++; $display("FAIL sw_one_pulse got=%b exp=0000", keyPress); end
    endtask

    task automatic test_reset_mid();
        rawIn = 4'b0110;
        repeat (4) tick();
        total++; if (keyState !== 4'b1000) begin bad++; $display("FAIL mid_pre_state got=%b exp=1000", keyState); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (keyState !== 4'b0) begin bad++; $display("FAIL mid_async_state got=%b exp=0000", keyState); end
        total++; if (keyEvent !== 4'b0) begin bad++; $display("FAIL mid_async_event got=%b exp=0000", keyEvent); end
        rawIn = 4'b1111;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if (keyState !== 4'b0 || keyPress !== 4'b0 || keyRelease !== 4'b0) begin
                bad++;
                $display("FAIL mid_quiet edge=%0d got=%b/%b/%b exp=0000/0000/0000", k, keyState, keyPress, keyRelease);
            end
        end
    endtask

`ifdef SM_KEY_REPEAT_EN
    task automatic test_repeat();
        logic ep;
        int   rel_cnt, late_press;
        logic seen_rel;
        rawIn = 4'b1110;
        repeat (6) tick();
        for (int off = 0; off <= 17; off++) begin
            if (off > 0) tick();
            ep = (off == 0 || off == 8 || off == 12 || off == 16);
            total++; if (keyPress[0] !== ep) begin bad++; $display("FAIL rpt_press off=%0d got=%b exp=%b", off, keyPress[0], ep); end
        end
        rawIn = 4'b1111;
        rel_cnt = 0; late_press = 0; seen_rel = 1'b0;
        repeat (30) begin
            tick();
            if (seen_rel && keyPress[0]) late_press++;
            if (keyRelease[0]) begin rel_cnt++; seen_rel = 1'b1; end
        end
        total++; if (rel_cnt != 1)    begin bad++; $display("FAIL rpt_release got=%0d exp=1", rel_cnt); end
        total++; if (late_press != 0) begin bad++; $display("FAIL rpt_after_rel got=%0d exp=0", late_press); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; rawIn = 4'b1111; eventClr = 4'b0;
        test_reset();
        test_press();
        test_bounce();
        test_set_wins();
        test_reset_mid();
`ifdef SM_KEY_REPEAT_EN
        test_repeat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm_key_debounce.md
Name: sm_key_debounce

Overview:
- Input-side conditioning block for board tops: the inbound counterpart of the register/HEX/LED output path.
- Takes raw, asynchronous, bouncy KEY/SW/GPIO lines and synchronises them.
- Debounces each line independently.
- Presents the CPU/GPIO side with clean levels, one-cycle press pulses and sticky event flags with a clear handshake.
- Sits between board pins and sm_top GpioInput (or any register-mapped input port).

Parameters:
- WIDTH, 4, number of independent input channels.
- DEBOUNCE_CYCLES, 16, consecutive stable clk cycles needed to accept a new level (must be >= 1).
- ACTIVE_LOW, 1, 1 = raw line low means pressed (DE1 KEY); 0 = high means pressed.
- REPEAT_DELAY, 1024, cycles a key must be held before the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 256, cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rawIn  input  WIDTH  raw asynchronous pin levels.
- keyState  output  WIDTH  debounced level per channel; 1 = pressed after polarity correction.
- keyPress  output  WIDTH  one-cycle pulse on debounced press (0->1).
- keyRelease  output  WIDTH  one-cycle pulse on debounced release (1->0).
- keyEvent  output  WIDTH  sticky flag per channel; set by keyPress (or repeat pulse).
- eventClr  input  WIDTH  per-channel clear of keyEvent; level-sampled each cycle.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Sync flops load the inactive raw level: 1 if ACTIVE_LOW, else 0.
  - Debounce counters = 0.
  - keyState, keyPress, keyRelease, keyEvent = 0.
  - No spurious pulse on reset release, even if a key is held. A held key is reported DEBOUNCE_CYCLES+2 edges after reset deassertion.
- Sync stage:
  - Two-flop synchroniser per channel.
  - Polarity applied after the synchroniser: pressed = ACTIVE_LOW ? ~sync : sync.
- Debounce, per channel:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - If pressed == keyState: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: keyState <= pressed, counter <= 0.
  - Else: counter <= counter+1.
  - Any bounce back to the current level restarts the count.
- Latency: a clean raw change just before edge 0 appears on keyState after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges total.
- Pulses:
  - keyPress/keyRelease are registered. They are high exactly in the cycle keyState changes, for one cycle only.
- keyEvent:
  - Set on keyPress (or repeat pulse); cleared when eventClr is high.
  - Simultaneous set and clear in the same cycle: set wins, so no event is lost.
  - Clearing an already-clear flag is a no-op.
- Channels are fully independent; no shared counter.
- Counter never wraps: it saturates at the compare point by construction.

Optional Feature:
- Macro SM_KEY_REPEAT_EN.
- Defined:
  - Per-channel repeat state machine with states IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on keyPress; the repeat counter is cleared.
  - DELAY -> REPEAT when held for REPEAT_DELAY cycles; emits one keyPress pulse.
  - In REPEAT, a keyPress pulse is emitted every REPEAT_PERIOD cycles.
  - Any state -> IDLE on keyRelease (release takes priority over a coincident repeat pulse).
  - Repeat pulses also set keyEvent.
- Undefined: no repeat logic or counters are synthesised. keyPress fires once per debounced press. REPEAT_* parameters are ignored.

Decomposition:
- Shared package sm_io_pkg:
  - Default DEBOUNCE_CYCLES / REPEAT_* constants.
  - Repeat state enum (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2).
  - Helper function for counter width.
- One natural sub-module, sm_debounce_ch: single-channel sync + debounce + edge pulses (+ repeat FSM under the macro).
- sm_key_debounce instantiates WIDTH copies via generate and holds the keyEvent register vector.

Test Plan:
- Reset with rawIn=4'b1110 held (ACTIVE_LOW=1, DEBOUNCE_CYCLES=4) -> all outputs 0 during reset. After release, keyState[0]=1 at edge 6 and keyPress[0] pulses 1 cycle; no pulse on channels 1-3.
- Clean press on ch1 (rawIn[1] 1->0) -> keyState[1] rises exactly 6 edges later. keyPress[1] high 1 cycle. keyEvent[1] stays 1 until eventClr[1] is asserted, then 0 the next cycle.
- Bounce on ch2: toggle every 2 cycles for 20 cycles, then settle low -> no keyState change during the bounce. A single keyPress 6 edges after settling.
- eventClr[3] asserted in the same cycle as keyPress[3] -> keyEvent[3]=1 afterwards (set wins).
- Assert rst_n low mid-count (counter=2) on ch0 -> keyState/keyEvent go 0 asynchronously. No pulse after reset release if rawIn is inactive.
- SM_KEY_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, hold ch0 -> keyPress pulses at the debounced press, +8, +12, +16 cycles. Release -> keyRelease once, no further presses.
